// File: rtl/store_bcast_arb_pkg.sv
// store_bcast_arb_pkg: shared types and widths for the store broadcast arbiter.
// DATA_MEM_WIDTH is the data-memory word-address width used across the cores.
package store_bcast_arb_pkg;

    localparam int DATA_MEM_WIDTH = 10;

    // Source field wide enough for the largest supported core count (8).
    localparam int BCAST_SRC_W = 3;

    // A committed store: address and data are both resolved.
    typedef struct packed {
        logic [DATA_MEM_WIDTH-1:0] addr;
        logic [31:0]               data;
    } store_req_t;

    // One beat on the shared broadcast bus.
    typedef struct packed {
        logic                      valid;
        logic [DATA_MEM_WIDTH-1:0] addr;
        logic [31:0]               data;
        logic [BCAST_SRC_W-1:0]    src;
    } bcast_t;

endpackage

// File: rtl/store_bcast_arb_if.sv
// store_bcast_arb_if: per-core store request lanes plus the shared broadcast bus.
// With STORE_BCAST_STATS_EN defined, the stall and per-core grant counters are
// carried here as well.
interface store_bcast_arb_if
    import store_bcast_arb_pkg::*;
#(
    parameter int N_CORE = 4
) ();

    localparam int SRC_W = $clog2(N_CORE);

    logic [N_CORE-1:0]                     req_valid;
    logic [N_CORE-1:0]                     req_ready;
    logic [N_CORE-1:0][DATA_MEM_WIDTH-1:0] req_addr;
    logic [N_CORE-1:0][31:0]               req_data;
    logic                                  hold;

    logic                                  bcast_valid;
    logic [DATA_MEM_WIDTH-1:0]             bcast_addr;
    logic [31:0]                           bcast_data;
    logic [SRC_W-1:0]                      bcast_src;
    logic                                  all_empty;

`ifdef STORE_BCAST_STATS_EN
    logic [31:0]                           stall_cycles;
    logic [N_CORE-1:0][31:0]               grant_cnt;

    modport master (
        output req_valid, req_addr, req_data, hold,
        input  req_ready, bcast_valid, bcast_addr, bcast_data, bcast_src, all_empty,
        input  stall_cycles, grant_cnt
    );

    modport slave (
        input  req_valid, req_addr, req_data, hold,
        output req_ready, bcast_valid, bcast_addr, bcast_data, bcast_src, all_empty,
        output stall_cycles, grant_cnt
    );
`else
    modport master (
        output req_valid, req_addr, req_data, hold,
        input  req_ready, bcast_valid, bcast_addr, bcast_data, bcast_src, all_empty
    );

    modport slave (
        input  req_valid, req_addr, req_data, hold,
        output req_ready, bcast_valid, bcast_addr, bcast_data, bcast_src, all_empty
    );
`endif

endinterface

// File: rtl/store_bcast_fifo.sv
// store_bcast_fifo: one core's small in-order store queue. Push and pop may
// happen on the same edge; the caller only pops when count is non-zero and
// only pushes when there is room (or a pop frees one).
module store_bcast_fifo
    import store_bcast_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  store_req_t             push_data,
    input  logic                   pop,
    output store_req_t             head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    store_req_t       mem_q [DEPTH];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; when full with a same-edge pop, the slot written is the
    // one being popped, whose value was already consumed from head.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/store_bcast_arb.sv
// store_bcast_arb: per-core store queues drained one store per cycle, in
// round-robin order, onto a registered broadcast bus snooped by every core.
// Optional feature macro: STORE_BCAST_STATS_EN adds stall_cycles/grant_cnt.
module store_bcast_arb
    import store_bcast_arb_pkg::*;
#(
    parameter int N_CORE     = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    store_bcast_arb_if.slave bus
);

    localparam int SRC_W = $clog2(N_CORE);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [N_CORE-1:0] push;
    logic [N_CORE-1:0] pop;
    logic [N_CORE-1:0] eligible;
    logic [N_CORE-1:0] ready;
    logic [CNT_W-1:0]  count [N_CORE];
    store_req_t        head  [N_CORE];

    logic [SRC_W:0]    pick;
    logic              grant;
    logic [SRC_W-1:0]  grant_idx;

    logic [SRC_W-1:0]          rr_ptr_q,      rr_ptr_d;
    logic                      bcast_valid_q, bcast_valid_d;
    logic [DATA_MEM_WIDTH-1:0] bcast_addr_q,  bcast_addr_d;
    logic [31:0]               bcast_data_q,  bcast_data_d;
    logic [SRC_W-1:0]          bcast_src_q,   bcast_src_d;

    // First eligible index at or after start, wrapping; MSB of result = found.
    function automatic logic [SRC_W:0] rr_pick(input logic [N_CORE-1:0] elig,
                                               input logic [SRC_W-1:0]  start);
        logic             found;
        logic [SRC_W-1:0] idx;
        logic [SRC_W-1:0] sel;
        found = 1'b0;
        sel   = start;
        for (int k = 0; k < N_CORE; k++) begin
            idx = start + k[SRC_W-1:0];
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return {found, sel};
    endfunction

    for (genvar gi = 0; gi < N_CORE; gi++) begin : g_core
        store_req_t push_req;

        assign push_req     = '{addr: bus.req_addr[gi], data: bus.req_data[gi]};
        assign eligible[gi] = (count[gi] != '0);
        assign pop[gi]      = grant && (grant_idx == SRC_W'(gi));
        // A slot freed by this cycle's pop can be refilled on the same edge.
        assign ready[gi]    = (count[gi] < DEPTH_CNT) || pop[gi];
        assign push[gi]     = bus.req_valid[gi] && ready[gi];

        store_bcast_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[gi]),
            .push_data (push_req),
            .pop       (pop[gi]),
            .head      (head[gi]),
            .count     (count[gi])
        );
    end

    // Only queued entries compete, so a new request never bypasses to the bus.
    assign pick      = rr_pick(eligible, rr_ptr_q);
    assign grant     = !bus.hold && pick[SRC_W];
    assign grant_idx = pick[SRC_W-1:0];

    // Next broadcast beat and round-robin pointer; payload holds when idle.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        bcast_valid_d = 1'b0;
        bcast_addr_d  = bcast_addr_q;
        bcast_data_d  = bcast_data_q;
        bcast_src_d   = bcast_src_q;
        if (grant) begin
            rr_ptr_d      = grant_idx + 1'b1;
            bcast_valid_d = 1'b1;
            bcast_addr_d  = head[grant_idx].addr;
            bcast_data_d  = head[grant_idx].data;
            bcast_src_d   = grant_idx;
        end
    end

    // Broadcast output register and arbitration pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            bcast_valid_q <= 1'b0;
            bcast_addr_q  <= '0;
            bcast_data_q  <= '0;
            bcast_src_q   <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            bcast_valid_q <= bcast_valid_d;
            bcast_addr_q  <= bcast_addr_d;
            bcast_data_q  <= bcast_data_d;
            bcast_src_q   <= bcast_src_d;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.bcast_valid = bcast_valid_q;
    assign bus.bcast_addr  = bcast_addr_q;
    assign bus.bcast_data  = bcast_data_q;
    assign bus.bcast_src   = bcast_src_q;
    // Fence/sync drain status built only from queue counts and the bus register.
    assign bus.all_empty   = !(|eligible) && !bcast_valid_q;

`ifdef STORE_BCAST_STATS_EN
    logic [31:0]             stall_cycles_q, stall_cycles_d;
    logic [N_CORE-1:0][31:0] grant_cnt_q,    grant_cnt_d;

    // Saturating stall count and wrapping per-core grant counts.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        grant_cnt_d    = grant_cnt_q;
        if ((|eligible) && !grant && (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (grant)
            grant_cnt_d[grant_idx] = grant_cnt_q[grant_idx] + 32'd1;
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            grant_cnt_q    <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            grant_cnt_q    <= grant_cnt_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.grant_cnt    = grant_cnt_q;
`endif

endmodule

// File: tb/tb_store_bcast_arb.sv
// tb_store_bcast_arb: table-driven single-store vectors plus hand sequences for
// round-robin, backpressure, pointer skip, async reset and (with
// STORE_BCAST_STATS_EN) the statistics counters. Expected broadcasts go into a
// scoreboard queue when offered and are matched by a bus monitor.
module tb_store_bcast_arb;
    import store_bcast_arb_pkg::*;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    store_bcast_arb_if #(.N_CORE(N)) bus();

    store_bcast_arb #(
        .N_CORE     (N),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int     checks = 0;
    int     errors = 0;
    bcast_t sb[$];
    bcast_t mon_exp;

    typedef struct {
        int                        core;
        logic [DATA_MEM_WIDTH-1:0] addr;
        logic [31:0]               data;
        logic [1:0]                exp_src;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Advance past the next edge; outputs settle and new inputs are driven here.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input int core, input logic [DATA_MEM_WIDTH-1:0] a,
                         input logic [31:0] d, input bit expect_bcast);
        bus.req_valid[core] = 1'b1;
        bus.req_addr[core]  = a;
        bus.req_data[core]  = d;
        if (expect_bcast)
            sb.push_back('{valid: 1'b1, addr: a, data: d, src: BCAST_SRC_W'(core)});
    endtask

    // Bus monitor: every broadcast beat must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (bus.bcast_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bcast actual src=%0d addr=0x%0h required no broadcast",
                         bus.bcast_src, bus.bcast_addr);
            end else begin
                mon_exp = sb.pop_front();
                $display("txn src=%0d addr=0x%0h data=0x%08h",
                         bus.bcast_src, bus.bcast_addr, bus.bcast_data);
                check("mon_addr", 64'(bus.bcast_addr), 64'(mon_exp.addr));
                check("mon_data", 64'(bus.bcast_data), 64'(mon_exp.data));
                check("mon_src",  64'(bus.bcast_src),  64'(mon_exp.src));
            end
        end
    end

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.hold      = 1'b0;

        vecs[0] = '{1, 10'h01A, 32'hDEAD_BEEF, 2'd1};
        vecs[1] = '{0, 10'h3FF, 32'h0000_0000, 2'd0};
        vecs[2] = '{2, 10'h000, 32'hFFFF_FFFF, 2'd2};
        vecs[3] = '{3, 10'h155, 32'hA5A5_A5A5, 2'd3};

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_bcast_valid", 64'(bus.bcast_valid), 64'd0);
        check("rst_bcast_addr",  64'(bus.bcast_addr),  64'd0);
        check("rst_bcast_data",  64'(bus.bcast_data),  64'd0);
        check("rst_bcast_src",   64'(bus.bcast_src),   64'd0);
        check("rst_all_empty",   64'(bus.all_empty),   64'd1);
        reset = 1'b0;
        #1;
        check("rst_req_ready",   64'(bus.req_ready),   64'hF);

        // Single-store vectors: bus beat exactly one edge after the enqueue edge
        for (int i = 0; i < 4; i++) begin
            offer(vecs[i].core, vecs[i].addr, vecs[i].data, 1'b1);
            step();
            bus.req_valid = '0;
            #1;
            check("vec_no_bypass", 64'(bus.bcast_valid), 64'd0);
            check("vec_busy",      64'(bus.all_empty),   64'd0);
            step();
            check("vec_valid", 64'(bus.bcast_valid), 64'd1);
            check("vec_src",   64'(bus.bcast_src),   64'(vecs[i].exp_src));
            check("vec_addr",  64'(bus.bcast_addr),  64'(vecs[i].addr));
            check("vec_data",  64'(bus.bcast_data),  64'(vecs[i].data));
            step();
            check("vec_pulse_end", 64'(bus.bcast_valid), 64'd0);
            check("vec_all_empty", 64'(bus.all_empty),   64'd1);
        end

        // Round robin: every core enqueues two stores on the same cycles
        for (int c = 0; c < N; c++)
            offer(c, 10'(10'h100 + c), 32'hA000_0000 + 32'(c), 1'b1);
        step();
        for (int c = 0; c < N; c++)
            offer(c, 10'(10'h200 + c), 32'hB000_0000 + 32'(c), 1'b1);
        step();
        bus.req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            check("rr_valid", 64'(bus.bcast_valid), 64'd1);
            check("rr_src",   64'(bus.bcast_src),   64'(k % N));
            step();
        end
        check("rr_drained", 64'(bus.all_empty), 64'd1);

        // Backpressure on core 0 while hold is asserted
        bus.hold = 1'b1;
        offer(0, 10'h010, 32'h1111_0001, 1'b1);
        step();
        offer(0, 10'h011, 32'h1111_0002, 1'b1);
        step();
        offer(0, 10'h012, 32'h1111_0003, 1'b1);
        #1;
        check("full_ready0",  64'(bus.req_ready[0]), 64'd0);
        check("full_ready1",  64'(bus.req_ready[1]), 64'd1);
        step();
        check("full_held",    64'(bus.req_ready[0]), 64'd0);
        check("hold_no_bcast", 64'(bus.bcast_valid), 64'd0);
        bus.hold = 1'b0;
        #1;
        check("pop_frees_slot", 64'(bus.req_ready[0]), 64'd1);
        step();
        bus.req_valid = '0;
        check("bp_beat0", 64'(bus.bcast_valid), 64'd1);
        step();
        check("bp_beat1", 64'(bus.bcast_valid), 64'd1);
        step();
        check("bp_beat2", 64'(bus.bcast_valid), 64'd1);
        step();
        check("bp_done",  64'(bus.bcast_valid), 64'd0);
        check("bp_empty", 64'(bus.all_empty),   64'd1);

        // Pointer skip: pointer sits at 1, only core 3 eligible
        offer(3, 10'h033, 32'h3333_3333, 1'b1);
        step();
        bus.req_valid = '0;
        step();
        check("skip_valid", 64'(bus.bcast_valid), 64'd1);
        check("skip_src3",  64'(bus.bcast_src),   64'd3);
        offer(0, 10'h0A0, 32'h0000_00A0, 1'b1);
        offer(2, 10'h0A2, 32'h0000_00A2, 1'b1);
        step();
        bus.req_valid = '0;
        step();
        check("skip_wrap_src0", 64'(bus.bcast_src), 64'd0);
        step();
        check("skip_then_src2", 64'(bus.bcast_src), 64'd2);
        step();
        check("skip_empty", 64'(bus.all_empty), 64'd1);

        // Async reset mid-traffic: queue 2 full with a beat in flight
        bus.hold = 1'b1;
        offer(2, 10'h0C0, 32'hC0C0_0001, 1'b1);
        step();
        offer(2, 10'h0C1, 32'hC0C0_0002, 1'b0);
        step();
        bus.hold = 1'b0;
        offer(2, 10'h0C2, 32'hC0C0_0003, 1'b0);
        step();
        bus.req_valid = '0;
        check("mid_inflight", 64'(bus.bcast_valid), 64'd1);
        check("mid_busy",     64'(bus.all_empty),   64'd0);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_valid",     64'(bus.bcast_valid), 64'd0);
        check("mid_rst_all_empty", 64'(bus.all_empty),   64'd1);
        #2;
        reset = 1'b0;
        repeat (6) step();
        check("mid_rst_quiet", 64'(bus.all_empty), 64'd1);
`ifdef STORE_BCAST_STATS_EN
        check("stats_rst_stall",  64'(bus.stall_cycles), 64'd0);
        check("stats_rst_grant2", 64'(bus.grant_cnt[2]), 64'd0);
`endif

        // Stall accounting: five held cycles with a non-empty queue, then drain
        bus.hold = 1'b1;
        offer(2, 10'h0D0, 32'hD0D0_0001, 1'b1);
        step();
        offer(2, 10'h0D1, 32'hD0D0_0002, 1'b1);
        step();
        bus.req_valid = '0;
        repeat (4) step();
`ifdef STORE_BCAST_STATS_EN
        check("stats_stall5", 64'(bus.stall_cycles), 64'd5);
`endif
        check("stall_no_bcast", 64'(bus.bcast_valid), 64'd0);
        bus.hold = 1'b0;
        offer(2, 10'h0D2, 32'hD0D0_0003, 1'b1);
        step();
        bus.req_valid = '0;
        repeat (3) step();
        check("stall_drained", 64'(bus.all_empty), 64'd1);
`ifdef STORE_BCAST_STATS_EN
        check("stats_stall_hold", 64'(bus.stall_cycles), 64'd5);
        check("stats_grant2",     64'(bus.grant_cnt[2]), 64'd3);
        check("stats_grant0",     64'(bus.grant_cnt[0]), 64'd0);
`endif

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
